// File: rtl/conv_encoder_if.sv
// Handshake bundle for the convolutional encoder: serial bit input and packed codeword output.
// master drives message bits and accepts codewords; slave is the encoder.
interface conv_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       cw_valid;
    logic       cw_ready;
    logic [7:0] codeword;
    logic       cw_last;

    modport master (
        output in_valid, in_bit, in_last, cw_ready,
        input  in_ready, cw_valid, codeword, cw_last
    );

    modport slave (
        input  in_valid, in_bit, in_last, cw_ready,
        output in_ready, cw_valid, codeword, cw_last
    );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder packing four trellis steps per 8-bit codeword,
// with two zero tail steps and zero padding closing every frame.
//
// state  | meaning
// -------+------------------------------------------------------------
// ACCEPT | taking message bits, one trellis step per accepted bit
// FLUSH  | inserting tail/padding steps (u = 0) until the codeword fills
// HOLD   | codeword complete, waiting for downstream to take it
module conv_encoder #(
    parameter logic [2:0] G0 = 3'b111,
    parameter logic [2:0] G1 = 3'b101
) (
    input logic          clk,
    input logic          rst_n,
    conv_encoder_if.slave bus
);

    typedef enum logic [1:0] {ACCEPT, FLUSH, HOLD} state_t;

    state_t     state, state_nxt;
    logic [1:0] sr;
    logic [1:0] step;
    logic [1:0] tail;
    logic [1:0] tail_nxt;
    logic [7:0] cw_q;
    logic       cw_last_q;
    logic       end_pending;
    logic       do_step;
    logic       u;
    logic       in_ready;
    logic       cw_valid;
    logic       hold_done;
    logic [2:0] v;
    logic       c0, c1;

    assign v        = {u, sr[0], sr[1]};
    assign c0       = ^(v & G0);
    assign c1       = ^(v & G1);
    assign tail_nxt = (tail != 2'd0) ? tail - 2'd1 : 2'd0;

    assign bus.in_ready = in_ready;
    assign bus.cw_valid = cw_valid;
    assign bus.codeword = cw_q;
    assign bus.cw_last  = cw_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCEPT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_step   = 1'b0;
        u         = 1'b0;
        in_ready  = 1'b0;
        cw_valid  = 1'b0;
        hold_done = 1'b0;
        case (state)
            ACCEPT: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    do_step = 1'b1;
                    u       = bus.in_bit;
                    if (step == 2'd3)    state_nxt = HOLD;
                    else if (bus.in_last) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                do_step = 1'b1;
                if (step == 2'd3) state_nxt = HOLD;
            end
            HOLD: begin
                cw_valid = 1'b1;
                if (bus.cw_ready) begin
                    hold_done = 1'b1;
                    if (cw_last_q)           state_nxt = ACCEPT;
                    else if (tail != 2'd0)   state_nxt = FLUSH;
                    else                     state_nxt = ACCEPT;
                end
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= 2'd0;
            step        <= 2'd0;
            tail        <= 2'd0;
            cw_q        <= 8'h00;
            cw_last_q   <= 1'b0;
            end_pending <= 1'b0;
        end else begin
            if (do_step) begin
                cw_q[{step, 1'b0}] <= c0;
                cw_q[{step, 1'b1}] <= c1;
                sr                 <= {sr[0], u};
                step               <= step + 2'd1;
            end
            if (state == ACCEPT && bus.in_valid && bus.in_last) begin
                tail        <= 2'd2;
                end_pending <= 1'b1;
            end
            if (state == FLUSH) begin
                tail <= tail_nxt;
                // Frame ends in the codeword that this step completes once the tail is spent.
                if (step == 2'd3 && tail_nxt == 2'd0 && end_pending)
                    cw_last_q <= 1'b1;
            end
            if (hold_done) begin
                cw_q <= 8'h00;
                if (cw_last_q) begin
                    cw_last_q   <= 1'b0;
                    end_pending <= 1'b0;
                    sr          <= 2'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed cases plus random frames checked
// against a bit-level behavioural encoder model.
module tb_conv_encoder;

    logic clk;
    logic rst_n;
    int   nchk;
    int   nerr;

    conv_encoder_if ifc();

    conv_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: previous two inputs, packing position, pending word.
    logic [8:0] exp_q[$];
    int         m_pos;
    logic       m1, m2;
    logic [7:0] m_cur;
    logic       m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m1     = 1'b0;
        m2     = 1'b0;
        m_cur  = 8'h00;
        m_last = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic ub, input logic fin);
        int c0, c1;
        c0 = (int'(ub) + int'(m1) + int'(m2)) % 2;
        c1 = (int'(ub) + int'(m2)) % 2;
        m_cur = m_cur | 8'((c1 * 2 + c0) << (2 * m_pos));
        if (fin) m_last = 1'b1;
        m2 = m1;
        m1 = ub;
        m_pos++;
        if (m_pos == 4) begin
            exp_q.push_back({m_last, m_cur});
            m_cur  = 8'h00;
            m_pos  = 0;
            m_last = 1'b0;
        end
    endtask

    task automatic model_bit(input logic b, input logic l);
        model_step(b, 1'b0);
        if (l) begin
            model_step(1'b0, 1'b0);
            model_step(1'b0, 1'b1);
            while (m_pos != 0) model_step(1'b0, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && ifc.cw_valid && ifc.cw_ready) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $error("FAIL cw_unexpected observed=%0h expected=none", {ifc.cw_last, ifc.codeword});
            end else begin
                e = exp_q.pop_front();
                chk("cw_stream", {23'd0, ifc.cw_last, ifc.codeword}, {23'd0, e});
            end
        end
    end

    task automatic send_bit(input logic b, input logic l, output int waited);
        int n;
        n = 0;
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_bit   = b;
        ifc.in_last  = l;
        while (!ifc.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("in_ready_timeout", {31'd0, ifc.in_ready}, 32'd1);
        @(posedge clk);
        if (n < 40) model_bit(b, l);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        waited = n;
    endtask

    task automatic send4(input logic [3:0] bits, input logic last4);
        int w;
        for (int i = 0; i < 4; i++) send_bit(bits[i], (i == 3) ? last4 : 1'b0, w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic wait_cw();
        int n;
        n = 0;
        while (!ifc.cw_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_cw", {31'd0, ifc.cw_valid}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int         w, lowcnt, len;
        logic [7:0] cw2, held;
        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_bit   = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.cw_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        chk("rst_cw_valid", {31'd0, ifc.cw_valid}, 32'd0);
        chk("rst_codeword", {24'd0, ifc.codeword}, 32'h00);
        chk("rst_cw_last",  {31'd0, ifc.cw_last},  32'd0);

        // 1,0,1,1 -> 0x87, one-cycle HOLD
        send4(4'b1101, 1'b0);
        chk("t1_cw_valid", {31'd0, ifc.cw_valid}, 32'd1);
        chk("t1_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        chk("t1_codeword", {24'd0, ifc.codeword}, 32'h87);
        chk("t1_cw_last",  {31'd0, ifc.cw_last},  32'd0);
        @(posedge clk);
        #1;
        chk("t1_valid_drop", {31'd0, ifc.cw_valid}, 32'd0);
        chk("t1_ready_back", {31'd0, ifc.in_ready}, 32'd1);

        // single bit frame -> 0x37 with cw_last, next frame from sr = 0
        do_reset();
        send_bit(1'b1, 1'b1, w);
        wait_cw();
        chk("t2_codeword", {24'd0, ifc.codeword}, 32'h37);
        chk("t2_cw_last",  {31'd0, ifc.cw_last},  32'd1);
        send4(4'b1101, 1'b0);
        chk("t2_next_frame", {24'd0, ifc.codeword}, 32'h87);

        // in_last on step 3 -> 0x87 then 0x0E(last), in_ready low throughout
        do_reset();
        send4(4'b1101, 1'b1);
        chk("t3_cw1", {24'd0, ifc.codeword}, 32'h87);
        chk("t3_cw1_last", {31'd0, ifc.cw_last}, 32'd0);
        lowcnt = 0;
        cw2 = 8'h00;
        while (!ifc.in_ready && lowcnt < 30) begin
            if (ifc.cw_valid && ifc.cw_last) cw2 = ifc.codeword;
            @(posedge clk);
            #1;
            lowcnt++;
        end
        chk("t3_cw2", {24'd0, cw2}, 32'h0E);
        chk("t3_ready_low_cycles", lowcnt, 32'd6);

        // backpressure: codeword held for 5 cycles
        do_reset();
        ifc.cw_ready = 1'b0;
        send4(4'($urandom_range(0, 15)), 1'b0);
        held = exp_q[0][7:0];
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {31'd0, ifc.cw_valid}, 32'd1);
            chk("t4_hold_cw", {24'd0, ifc.codeword}, {24'd0, held});
            chk("t4_hold_in_ready", {31'd0, ifc.in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        ifc.cw_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_accepted", {31'd0, ifc.cw_valid}, 32'd0);

        // reset mid-codeword discards partial state
        do_reset();
        send_bit(1'b1, 1'b0, w);
        send_bit(1'b1, 1'b0, w);
        do_reset();
        chk("t5_cw_valid", {31'd0, ifc.cw_valid}, 32'd0);
        chk("t5_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        send4(4'b1101, 1'b0);
        chk("t5_codeword", {24'd0, ifc.codeword}, 32'h87);

        // continuous stream, sr carries across codewords
        do_reset();
        send4(4'b1101, 1'b0);
        send_bit(1'b1, 1'b0, w);
        chk("t6_bubble", w, 32'd1);
        send_bit(1'b0, 1'b0, w);
        send_bit(1'b1, 1'b0, w);
        send_bit(1'b1, 1'b0, w);
        chk("t6_cw2_not87", {31'd0, ifc.codeword != 8'h87}, 32'd1);
        drain();

        // random framed traffic
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++)
                send_bit(1'($urandom_range(0, 1)), (i == len - 1) ? 1'b1 : 1'b0, w);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder that produces the 8-bit codewords consumed by the Viterbi decoder's soft-symbol mapping stage. It accepts a framed serial bit stream on a valid/ready handshake. Four trellis steps are packed into each codeword. Each frame is terminated with K-1 zero tail bits so that every frame ends in state 0. Codewords leave on a second valid/ready handshake with a frame-end marker.

## Interface
- G0, 3'b111, generator polynomial for output bit c0 (bit 2 = current input, bit 1 = previous input, bit 0 = input before that)
- G1, 3'b101, generator polynomial for output bit c1, same bit ordering as G0
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_bit/in_last are valid
- in_ready  output  1  encoder accepts a bit this cycle
- in_bit  input  1  message bit
- in_last  input  1  final message bit of the frame; sampled only on an accepted bit
- cw_valid  output  1  codeword/cw_last are valid
- cw_ready  input  1  downstream accepts the codeword
- codeword  output  8  packed code bits: step k writes bit 2k = c0, bit 2k+1 = c1 (k = 0..3)
- cw_last  output  1  codeword contains the frame's final tail step

## Operation
- State registers:
  - shift register sr[1:0], where sr[0] is the most recent input;
  - step counter step[1:0];
  - tail counter tail[1:0];
  - codeword register cw_q[7:0];
  - last flag.
- Encoder step with input u: form v = {u, sr[0], sr[1]}; c0 = ^(v & G0); c1 = ^(v & G1); write c0/c1 into cw_q at step; then sr <= {sr[0], u}; step <= step + 1 (wraps 3 -> 0).
- FSM states:
  - ACCEPT: in_ready = 1. On in_valid, perform a step with u = in_bit.
    - If in_last = 1: set tail = 2 and end_pending = 1.
    - If this was step 3: go to HOLD. Otherwise, if in_last = 1, go to FLUSH; otherwise stay in ACCEPT.
  - FLUSH: in_ready = 0. Perform one step per cycle with u = 0, decrementing tail while tail > 0. Steps taken after tail reaches 0 are padding steps, also with u = 0 (they output 00, since sr = 0).
    - When a step lands on step 3: go to HOLD. If tail = 0 after that step, set cw_last.
  - HOLD: in_ready = 0, cw_valid = 1. On cw_ready:
    - clear cw_q;
    - if cw_last: clear cw_last and end_pending, set sr = 0, go to ACCEPT;
    - else if tail > 0: go to FLUSH;
    - else go to ACCEPT.
- Frame boundary cases:
  - in_last at step 0 or 1: tail steps and padding complete in the same codeword; that codeword has cw_last = 1.
  - in_last at step 2: tail step 1 lands at step 3. The next codeword carries tail step 2 at step 0 plus padding at steps 1..3, and has cw_last = 1.
  - in_last at step 3: the current codeword has cw_last = 0. The next codeword carries both tail steps at steps 0..1 plus padding at steps 2..3, and has cw_last = 1.
- Consecutive frames start from sr = 0. A frame without in_last continues encoding with sr carried over.
- Reset mid-operation discards the partial codeword and any pending tail; the encoder returns to ACCEPT with sr = 0 and step = 0.

## Timing
- Reset values:
  - in_ready = 1 (ACCEPT is the reset state);
  - cw_valid = 0, codeword = 8'h00, cw_last = 0;
  - sr = 0, step = 0, tail = 0.
- Upstream must hold in_valid = 0 while rst_n = 0.
- Latency: when the 4th step of a codeword completes on edge t, cw_valid = 1 from t+1.
- codeword and cw_last are registered and stable while cw_valid = 1 and cw_ready = 0.
- in_ready is a pure decode of the FSM state. It is 0 in FLUSH and HOLD and never depends combinationally on cw_ready.
- The HOLD handshake completes on the edge where cw_valid && cw_ready. The next state is active from the following cycle.
- Steady-state throughput: 4 bits in 5 cycles. in_ready is low for exactly 1 cycle per codeword when cw_ready stays high.
- Simultaneous in_valid and in_last at step 3: the codeword is emitted with cw_last = 0, and FLUSH follows immediately after the HOLD handshake.

## Test plan
- After reset, bits 1,0,1,1 (in_last = 0), cw_ready = 1 -> codeword = 8'h87, cw_last = 0, cw_valid high for 1 cycle; in_ready low for exactly that cycle.
- After reset, single bit 1 with in_last = 1 -> codeword = 8'h37, cw_last = 1; the next frame starts with sr = 0.
- After reset, bits 1,0,1,1 with in_last on the 4th bit -> 8'h87 (cw_last = 0), then 8'h0E (cw_last = 1); in_ready stays 0 until 8'h0E is accepted.
- Complete a codeword, then hold cw_ready = 0 for 5 cycles -> cw_valid = 1 and codeword constant for all 5 cycles, in_ready = 0; accepted on the first cw_ready = 1.
- Assert rst_n = 0 after 2 accepted bits -> cw_valid = 0, in_ready = 1. Then apply bits 1,0,1,1 -> 8'h87 (no residue from the aborted frame).
- Stream 8 continuous bits 1,0,1,1,1,0,1,1 with cw_ready = 1 -> two codewords, in_ready low exactly one cycle after each 4th bit. The second codeword differs from 8'h87 because sr carries over (sr = 2'b11 at its start).
